// File: rtl/embertrail_pkg.sv
// Shared types and constants for the embertrail data-memory responder.
package embertrail_pkg;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_READ_LAT = 2;

  // Per-bank direction encoding on the core bus
  localparam logic RW_RD = 1'b1;
  localparam logic RW_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR      = 2'd3
  } dmemState_t;

  // Even parity: the stored bit makes the XOR of data plus parity equal zero
  function automatic logic evenParity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/embertrail_dmem_bank.sv
// Single-port memory bank: synchronous write, registered read.
// Contents are never reset; only the controller state is.
module embertrail_dmem_bank #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              gclk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wrData,
  output logic [WORD_W-1:0] rdData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // One access per enabled cycle: write the word or capture it into rdData
  always_ff @(posedge gclk) begin
    if (en) begin
      if (we) mem[addr] <= wrData;
      else    rdData    <= mem[addr];
    end
  end

endmodule

// File: rtl/embertrail_dmem_resp.sv
// Two-bank data-memory responder for the embertrail core.
// Accepts one request at a time, returns read data after READ_LAT cycles,
// and flags misaligned or conflicting requests on oBankErr.
// Optional build macro: EMBERTRAIL_DMEM_PARITY_EN adds a per-word even
// parity bit, checked on every read.
module embertrail_dmem_resp
  import embertrail_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [31:0] iDataAddrBus,
  input  logic [31:0] iDataWrData,
  input  logic        iDataMem1RW,
  input  logic        iDataMem2RW,
  input  logic        iData1BusEn,
  input  logic        iData2BusEn,
  output logic [31:0] oDataDataBus,
  output logic        oDataValid,
  output logic        oBusy,
  output logic        oBankErr
);

`ifdef EMBERTRAIL_DMEM_PARITY_EN
  localparam int WORD_W = 33;
`else
  localparam int WORD_W = 32;
`endif
  localparam int         NUM_BANKS = 2;
  localparam logic [2:0] LAT_LAST  = 3'(READ_LAT - 1);

  dmemState_t state;
  logic [2:0] latCnt;
  logic       selBank;

  logic [NUM_BANKS-1:0]             busEn, busRw, bankEn, bankWe;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bankRd;
  logic [WORD_W-1:0]                wrWord, selWord;
  logic [ADDR_W-1:0]                wordAddr;
  logic misaligned, conflict, oneReq, reqRw, accept;
  logic unusedAddrHi;

  assign busEn      = {iData2BusEn, iData1BusEn};
  assign busRw      = {iDataMem2RW, iDataMem1RW};
  assign misaligned = |iDataAddrBus[1:0];
  assign conflict   = &busEn;
  assign oneReq     = ^busEn;
  assign reqRw      = busRw[iData2BusEn];
  assign wordAddr   = iDataAddrBus[ADDR_W+1:2];
  // Upper address bits are deliberately dropped so accesses wrap per bank
  assign unusedAddrHi = &{1'b0, iDataAddrBus[31:ADDR_W+2]};

  // Gate with reset so a strobe held during reset cannot touch the banks
  assign accept = iReset && (state == IDLE) && oneReq && !misaligned;

`ifdef EMBERTRAIL_DMEM_PARITY_EN
  assign wrWord = {evenParity(iDataWrData), iDataWrData};
`else
  assign wrWord = iDataWrData;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    assign bankEn[b] = accept && busEn[b];
    assign bankWe[b] = (busRw[b] == RW_WR);

    embertrail_dmem_bank #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
    ) uBank (
      .gclk   (iClock),
      .en     (bankEn[b]),
      .we     (bankWe[b]),
      .addr   (wordAddr),
      .wrData (wrWord),
      .rdData (bankRd[b])
    );
  end

  // The bank picked at accept stays selected until the read completes
  assign selWord = bankRd[selBank];

  // Request FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state        <= IDLE;
      latCnt       <= '0;
      selBank      <= 1'b0;
      oDataDataBus <= '0;
      oDataValid   <= 1'b0;
      oBusy        <= 1'b0;
      oBankErr     <= 1'b0;
    end else begin
      oDataValid <= 1'b0;
      oBankErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (conflict || (oneReq && misaligned)) begin
            oBankErr <= 1'b1;
          end else if (oneReq) begin
            selBank <= iData2BusEn;
            latCnt  <= '0;
            oBusy   <= 1'b1;
            state   <= (reqRw == RW_RD) ? RD_WAIT : WR;
          end
        end
        RD_WAIT: begin
          if (latCnt == LAT_LAST) begin
            state        <= RD_DONE;
            oDataValid   <= 1'b1;
            oDataDataBus <= selWord[31:0];
`ifdef EMBERTRAIL_DMEM_PARITY_EN
            oBankErr     <= ^selWord;
`endif
          end else begin
            latCnt <= latCnt + 3'd1;
          end
        end
        RD_DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        WR: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_embertrail_dmem_resp.sv
// Scoreboard bench for embertrail_dmem_resp: stimulus tasks push expected
// pulses, a negedge monitor pops and compares them.
module tb_embertrail_dmem_resp;

  localparam int LAT = 2;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [31:0] iDataAddrBus, iDataWrData;
  logic        iDataMem1RW, iDataMem2RW, iData1BusEn, iData2BusEn;
  logic [31:0] oDataDataBus;
  logic        oDataValid, oBusy, oBankErr;

  embertrail_dmem_resp #(.ADDR_W(10), .READ_LAT(LAT)) dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iDataAddrBus (iDataAddrBus),
    .iDataWrData  (iDataWrData),
    .iDataMem1RW  (iDataMem1RW),
    .iDataMem2RW  (iDataMem2RW),
    .iData1BusEn  (iData1BusEn),
    .iData2BusEn  (iData2BusEn),
    .oDataDataBus (oDataDataBus),
    .oDataValid   (oDataValid),
    .oBusy        (oBusy),
    .oBankErr     (oBankErr)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    bit          v;
    bit          e;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   nCyc    = 0;
  int   nChecks = 0;
  int   nErr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, nCyc);
    end
  endtask

  // Monitor: every valid/err pulse must match the head of the queue
  always @(negedge iClock) begin
    nCyc++;
    if (oDataValid || oBankErr) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErr++;
        $display("FAIL unexpected pulse: valid=%0b err=%0b data=0x%08h cycle %0d",
                 oDataValid, oBankErr, oDataDataBus, nCyc);
      end else begin
        cur = expQ.pop_front();
        chk("pulse cycle", nCyc, cur.c);
        chk("valid", {31'b0, oDataValid}, {31'b0, cur.v});
        chk("bankErr", {31'b0, oBankErr}, {31'b0, cur.e});
        if (cur.v) chk("read data", oDataDataBus, cur.d);
      end
    end
  end

  task automatic idleBus();
    iData1BusEn = 1'b0;
    iData2BusEn = 1'b0;
    iDataMem1RW = 1'b1;
    iDataMem2RW = 1'b1;
  endtask

  // All ops start at posedge+1 and end at posedge+1 with the DUT idle
  task automatic wrOp(input int bank, input logic [31:0] addr, input logic [31:0] data);
    iDataAddrBus = addr;
    iDataWrData  = data;
    iData1BusEn  = (bank == 1);
    iData2BusEn  = (bank == 2);
    iDataMem1RW  = 1'b0;
    iDataMem2RW  = 1'b0;
    @(posedge iClock); #1;
    idleBus();
    chk("wr busy", {31'b0, oBusy}, 32'd1);
    @(posedge iClock); #1;
    chk("wr busy drop", {31'b0, oBusy}, 32'd0);
  endtask

  task automatic rdOp(input int bank, input logic [31:0] addr, input logic [31:0] data, input bit err);
    expQ.push_back('{v: 1'b1, e: err, d: data, c: nCyc + 2 + LAT});
    iDataAddrBus = addr;
    iData1BusEn  = (bank == 1);
    iData2BusEn  = (bank == 2);
    iDataMem1RW  = 1'b1;
    iDataMem2RW  = 1'b1;
    @(posedge iClock); #1;
    idleBus();
    chk("rd busy", {31'b0, oBusy}, 32'd1);
    repeat (LAT) @(posedge iClock);
    #1;
    chk("rd busy at valid", {31'b0, oBusy}, 32'd1);
    @(posedge iClock); #1;
    chk("rd busy drop", {31'b0, oBusy}, 32'd0);
  endtask

  task automatic errOp(input bit en1, input bit en2, input bit rw, input logic [31:0] addr,
                       input logic [31:0] data);
    expQ.push_back('{v: 1'b0, e: 1'b1, d: 32'h0, c: nCyc + 2});
    iDataAddrBus = addr;
    iDataWrData  = data;
    iData1BusEn  = en1;
    iData2BusEn  = en2;
    iDataMem1RW  = rw;
    iDataMem2RW  = rw;
    @(posedge iClock); #1;
    idleBus();
    chk("err busy", {31'b0, oBusy}, 32'd0);
    @(posedge iClock); #1;
    chk("err busy after", {31'b0, oBusy}, 32'd0);
  endtask

  initial begin
    iReset       = 1'b0;
    iDataAddrBus = 32'h0;
    iDataWrData  = 32'h0;
    idleBus();
    repeat (2) @(posedge iClock);
    #1;
    chk("reset data", oDataDataBus, 32'h0);
    chk("reset valid", {31'b0, oDataValid}, 32'd0);
    chk("reset busy", {31'b0, oBusy}, 32'd0);
    chk("reset bankErr", {31'b0, oBankErr}, 32'd0);
    iReset = 1'b1;
    @(posedge iClock); #1;

    // Basic write then read, latency checked by the monitor
    wrOp(1, 32'h10, 32'hDEADBEEF);
    rdOp(1, 32'h10, 32'hDEADBEEF, 1'b0);

    // Read accepted right after the WR cycle sees the new word
    wrOp(1, 32'h14, 32'h12345678);
    rdOp(1, 32'h14, 32'h12345678, 1'b0);

    // Bank conflict must leave both banks untouched
    wrOp(1, 32'h20, 32'h11111111);
    wrOp(2, 32'h20, 32'h22222222);
    errOp(1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    rdOp(1, 32'h20, 32'h11111111, 1'b0);
    rdOp(2, 32'h20, 32'h22222222, 1'b0);

    // Misaligned read and write: error pulse only, no access
    errOp(1'b1, 1'b0, 1'b1, 32'h03, 32'h0);
    errOp(1'b0, 1'b1, 1'b0, 32'h22, 32'hFFFFFFFF);
    rdOp(2, 32'h20, 32'h22222222, 1'b0);

    // Address wraps modulo 1024 words
    wrOp(2, 32'h1000, 32'hA5A55A5A);
    rdOp(2, 32'h0, 32'hA5A55A5A, 1'b0);

    // Read data bus holds across a later write
    wrOp(1, 32'h40, 32'h77777777);
    chk("data hold", oDataDataBus, 32'hA5A55A5A);

    // Reset one cycle into a read: outputs clear, no late valid
    iDataAddrBus = 32'h10;
    iData1BusEn  = 1'b1;
    iDataMem1RW  = 1'b1;
    @(posedge iClock); #1;
    idleBus();
    chk("pre-reset busy", {31'b0, oBusy}, 32'd1);
    @(posedge iClock); #1;
    iReset = 1'b0;
    #1;
    chk("abort data", oDataDataBus, 32'h0);
    chk("abort valid", {31'b0, oDataValid}, 32'd0);
    chk("abort busy", {31'b0, oBusy}, 32'd0);
    chk("abort bankErr", {31'b0, oBankErr}, 32'd0);
    @(posedge iClock); #1;
    iReset = 1'b1;
    repeat (4) @(posedge iClock);
    #1;
    rdOp(1, 32'h10, 32'hDEADBEEF, 1'b0);

`ifdef EMBERTRAIL_DMEM_PARITY_EN
    // Corrupt one stored bit: data still returned with a parity error
    wrOp(1, 32'h30, 32'h0000000F);
    dut.gBank[0].uBank.mem[12] = dut.gBank[0].uBank.mem[12] ^ 33'h1;
    rdOp(1, 32'h30, 32'h0000000E, 1'b1);
`endif

    repeat (4) @(posedge iClock);
    #1;
    chk("pending expectations", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/embertrail_dmem_resp.md
EMBERTRAIL_DMEM_RESP -- requirements
Module: embertrail_dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width per bank (1024 words/bank).
REQ-002 SHALL have parameter READ_LAT, default 2, cycles from request accept to oDataValid (legal range 1..7).
REQ-003 SHALL have port iClock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port iReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iDataAddrBus, input, 32, byte address from core.
REQ-006 SHALL have port iDataWrData, input, 32, write data from core.
REQ-007 SHALL have ports iDataMem1RW / iDataMem2RW, input, 1 each, per-bank direction (1 = read, 0 = write).
REQ-008 SHALL have ports iData1BusEn / iData2BusEn, input, 1 each, per-bank request strobe.
REQ-009 SHALL have port oDataDataBus, output, 32, read data to core.
REQ-010 SHALL have port oDataValid, output, 1, single-cycle pulse marking oDataDataBus valid.
REQ-011 SHALL have port oBusy, output, 1, high while a request is in progress.
REQ-012 SHALL have port oBankErr, output, 1, single-cycle error pulse.

Function
REQ-013 SHALL accept a request only in IDLE when exactly one of iData1BusEn/iData2BusEn is high; requests while oBusy is high are ignored and the core holds them.
REQ-014 SHALL index the selected bank with iDataAddrBus[ADDR_W+1:2]; upper address bits ignored, so addresses wrap modulo bank size.
REQ-015 SHALL treat iDataAddrBus[1:0] != 0 as misaligned: no access, oBankErr pulses the cycle after the request, state stays IDLE.
REQ-016 SHALL treat both bus enables high in the same cycle as a bank conflict: no access to either bank, oBankErr pulses the next cycle, state stays IDLE.
REQ-017 SHALL implement FSM IDLE -> RD_WAIT (read accepted) -> RD_DONE (latency counter reaches READ_LAT-1) -> IDLE; IDLE -> WR (write accepted) -> IDLE.
REQ-018 SHALL, for reads, drive oDataDataBus and pulse oDataValid exactly READ_LAT cycles after the accept edge; oBusy high from accept until the cycle oDataValid is high, inclusive.
REQ-019 SHALL, for writes, update the word at the accept edge; oBusy high for exactly one cycle (WR); oDataValid not asserted.
REQ-020 SHALL hold oDataDataBus at the last read value until the next read completes.
REQ-021 SHALL return newly written data to a read of the same address accepted on the cycle after WR.

Reset
REQ-022 SHALL, on iReset low, asynchronously force state IDLE, latency counter 0, oDataDataBus 0, oDataValid 0, oBusy 0, oBankErr 0.
REQ-023 SHALL abort an in-flight read on reset with no oDataValid afterwards; memory contents are not cleared.

Configuration
REQ-024 SHALL, with EMBERTRAIL_DMEM_PARITY_EN defined, store an even-parity bit per word on write, check it on read, and on mismatch pulse oBankErr together with oDataValid (data still returned).
REQ-025 SHALL, without EMBERTRAIL_DMEM_PARITY_EN, omit parity storage and logic; oBankErr then reports only misalignment and conflicts.

Structure
REQ-026 SHALL take FSM state encoding, RW encoding constants (RD=1, WR=0) and default ADDR_W/READ_LAT from shared package embertrail_pkg.
REQ-027 SHALL instantiate one bank sub-module, embertrail_dmem_bank (single-port, synchronous write, registered read), twice.

Verification
REQ-028 SHALL cover: write 0xDEADBEEF bank1 addr 0x10, then read same -> oDataValid exactly 2 cycles after accept, data 0xDEADBEEF.
REQ-029 SHALL cover: iData1BusEn and iData2BusEn both high, addr 0x20 -> oBankErr one pulse, no write to either bank, oBusy stays 0.
REQ-030 SHALL cover: read addr 0x03 -> oBankErr one pulse, no oDataValid.
REQ-031 SHALL cover: write bank2 addr 0x1000 (ADDR_W=10), read bank2 addr 0x0 -> same data (wrap-around).
REQ-032 SHALL cover: iReset low one cycle after read accept -> all outputs 0 immediately, no later oDataValid; subsequent read returns pre-reset memory content.
REQ-033 SHALL cover (parity build): force a bit flip in stored word, read -> oDataValid and oBankErr high in the same cycle.
